// File: rtl/sim_clockgen_multi.sv
// Multi-channel divided clock generator with glitch-free run-time retune.
// Optional SIM_CLOCKGEN_STROBE_EN adds a registered clk_rise strobe per channel.
module sim_clockgen_multi #(
    parameter  int N_CH  = 4,
    parameter  int CNT_W = 16,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic             cfg_enable,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic [CNT_W-1:0] cfg_phase,
    output logic             cfg_err,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  clk_rise,
    output logic [N_CH-1:0]  locked
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PHASE = 2'd1,
        RUN   = 2'd2
    } st_t;

    localparam logic [CH_W:0]    NCH = (CH_W + 1)'(N_CH);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic             pend;
    logic             pend_en;
    logic             pend_bad;
    logic             pend_nx;
    logic             xfer;
    logic [CH_W-1:0]  pend_ch;
    logic [CNT_W-1:0] pend_h;
    logic [CNT_W-1:0] pend_p;

    st_t              st   [N_CH];
    logic [CNT_W-1:0] cnt  [N_CH];
    logic [CNT_W-1:0] hreg [N_CH];
    logic [CNT_W-1:0] preg [N_CH];
    logic [N_CH-1:0]  apply;

    assign xfer     = cfg_valid && cfg_ready;
    assign pend_bad = {1'b0, pend_ch} >= NCH;

    // A running channel only accepts a change on its 1->0 toggle edge.
    always_comb begin
        apply = '0;
        for (int i = 0; i < N_CH; i++) begin
            apply[i] = pend && (pend_ch == CH_W'(i)) &&
                       ((st[i] != RUN) ||
                        (clk_out[i] && (cnt[i] == hreg[i] - ONE)));
        end
    end

    assign pend_nx = xfer || (pend && !pend_bad && !(|apply));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= 1'b0;
            pend_ch   <= '0;
            pend_en   <= 1'b0;
            pend_h    <= '0;
            pend_p    <= '0;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
        end else begin
            pend      <= pend_nx;
            cfg_ready <= !pend_nx;
            cfg_err   <= pend && pend_bad;
            if (xfer) begin
                pend_ch <= cfg_ch;
                pend_en <= cfg_enable;
                pend_h  <= cfg_half;
                pend_p  <= cfg_phase;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_out <= '0;
            locked  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                st[i]   <= IDLE;
                cnt[i]  <= '0;
                hreg[i] <= ONE;
                preg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (apply[i]) begin
                    clk_out[i] <= 1'b0;
                    locked[i]  <= 1'b0;
                    if (pend_en) begin
                        hreg[i] <= (pend_h == '0) ? ONE : pend_h;
                        preg[i] <= pend_p;
                        cnt[i]  <= '0;
                        st[i]   <= PHASE;
                    end else begin
                        st[i] <= IDLE;
                    end
                end else begin
                    case (st[i])
                        IDLE: begin
                            clk_out[i] <= 1'b0;
                        end
                        PHASE: begin
                            if (cnt[i] == preg[i]) begin
                                clk_out[i] <= 1'b1;
                                locked[i]  <= 1'b1;
                                cnt[i]     <= '0;
                                st[i]      <= RUN;
                            end else begin
                                cnt[i] <= cnt[i] + ONE;
                            end
                        end
                        RUN: begin
                            if (cnt[i] == hreg[i] - ONE) begin
                                clk_out[i] <= !clk_out[i];
                                cnt[i]     <= '0;
                            end else begin
                                cnt[i] <= cnt[i] + ONE;
                            end
                        end
                        default: begin
                            clk_out[i] <= 1'b0;
                            locked[i]  <= 1'b0;
                            st[i]      <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

`ifdef SIM_CLOCKGEN_STROBE_EN
    logic [N_CH-1:0] rise_nx;

    always_comb begin
        rise_nx = '0;
        for (int i = 0; i < N_CH; i++) begin
            rise_nx[i] = !apply[i] &&
                         (((st[i] == PHASE) && (cnt[i] == preg[i])) ||
                          ((st[i] == RUN) && !clk_out[i] &&
                           (cnt[i] == hreg[i] - ONE)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_rise <= '0;
        end else begin
            clk_rise <= rise_nx;
        end
    end
`else
    assign clk_rise = '0;
`endif

endmodule
